// File: rtl/dbus_pkg.sv
// dbus_pkg: opcode/response constants, access-size encoding and FSM state type
// shared by dbus_byte_master and anything that talks to it.
package dbus_pkg;

    localparam logic [7:0] OpWrite  = 8'h57;
    localparam logic [7:0] OpRead   = 8'h52;
    localparam logic [7:0] RspAck   = 8'h06;
    localparam logic [7:0] RspNak   = 8'h15;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StCmd,
        StWaitRsp,
        StTx
    } dbus_state_e;

    function automatic logic is_known_opcode(input logic [7:0] op);
        return (op == OpWrite) || (op == OpRead);
    endfunction

endpackage

// File: rtl/dbus_byte_master.sv
// dbus_byte_master: turns byte-serial command frames (opcode, LE address, LE write data)
// into single word-sized bus commands and streams back ACK/NAK plus LE read data.
// Optional build macro DBUS_MASTER_TIMEOUT_EN adds a command/response timeout that
// answers NAK after RSP_TIMEOUT cycles in CMD/WAIT_RSP.
module dbus_byte_master
    import dbus_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        dbus_cmd_valid,
    input  logic        dbus_cmd_ready,
    output logic        dbus_cmd_payload_wr,
    output logic [31:0] dbus_cmd_payload_address,
    output logic [31:0] dbus_cmd_payload_data,
    output logic [1:0]  dbus_cmd_payload_size,
    input  logic        dbus_rsp_ready,
    input  logic        dbus_rsp_error,
    input  logic [31:0] dbus_rsp_data,
    output logic        busy
);

    dbus_state_e r_state, w_state_next;
    logic [1:0]  r_cnt, w_cnt_next;
    logic        r_is_wr, w_is_wr_next;
    logic [31:0] r_addr, w_addr_next;
    logic [31:0] r_wdata, w_wdata_next;
    // Response serializer: low byte is on the wire, upper bytes hold captured read data.
    logic [39:0] r_tx_shift, w_tx_shift_next;
    logic        r_tx_long, w_tx_long_next;
    logic        r_tx_phase, w_tx_phase_next;
    logic        w_rx_fire, w_tx_fire, w_timeout;

    assign rx_ready  = (r_state == StIdle) || (r_state == StAddr) || (r_state == StWdata);
    assign tx_valid  = (r_state == StTx);
    assign tx_data   = r_tx_shift[7:0];
    assign busy      = (r_state != StIdle);
    assign w_rx_fire = rx_valid && rx_ready;
    assign w_tx_fire = tx_valid && tx_ready;

    assign dbus_cmd_valid           = (r_state == StCmd);
    assign dbus_cmd_payload_wr      = r_is_wr;
    assign dbus_cmd_payload_address = r_addr;
    assign dbus_cmd_payload_data    = r_wdata;
    assign dbus_cmd_payload_size    = (r_state == StCmd) ? SizeWord : 2'b00;

`ifdef DBUS_MASTER_TIMEOUT_EN
    localparam int unsigned ToWidth = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    logic [ToWidth-1:0] r_to_cnt;

    assign w_timeout = (r_to_cnt == ToWidth'(RSP_TIMEOUT - 1));

    // Timeout counter: runs across CMD and WAIT_RSP, cleared everywhere else.
    always_ff @(posedge clk) begin
        if (reset || !((r_state == StCmd) || (r_state == StWaitRsp))) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state logic: frame parsing, command handshake, response capture, TX serializing.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_is_wr_next    = r_is_wr;
        w_addr_next     = r_addr;
        w_wdata_next    = r_wdata;
        w_tx_shift_next = r_tx_shift;
        w_tx_long_next  = r_tx_long;
        w_tx_phase_next = r_tx_phase;
        case (r_state)
            StIdle: begin
                if (w_rx_fire) begin
                    w_cnt_next = 2'd0;
                    if (is_known_opcode(rx_data)) begin
                        w_state_next = StAddr;
                        w_is_wr_next = (rx_data == OpWrite);
                        w_addr_next  = 32'h0;
                        w_wdata_next = 32'h0;
                    end else begin
                        w_state_next    = StTx;
                        w_tx_shift_next = {32'h0, RspNak};
                        w_tx_long_next  = 1'b0;
                        w_tx_phase_next = 1'b0;
                    end
                end
            end
            StAddr: begin
                if (w_rx_fire) begin
                    w_addr_next = {rx_data, r_addr[31:8]};
                    w_cnt_next  = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = r_is_wr ? StWdata : StCmd;
                    end
                end
            end
            StWdata: begin
                if (w_rx_fire) begin
                    w_wdata_next = {rx_data, r_wdata[31:8]};
                    w_cnt_next   = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_state_next = StCmd;
                    end
                end
            end
            StCmd: begin
                w_cnt_next      = 2'd0;
                w_tx_phase_next = 1'b0;
                if (dbus_cmd_ready) begin
                    if (r_is_wr) begin
                        w_state_next    = StTx;
                        w_tx_shift_next = {32'h0, RspAck};
                        w_tx_long_next  = 1'b0;
                    end else begin
                        w_state_next = StWaitRsp;
                    end
                end else if (w_timeout) begin
                    w_state_next    = StTx;
                    w_tx_shift_next = {32'h0, RspNak};
                    w_tx_long_next  = 1'b0;
                end
            end
            StWaitRsp: begin
                w_cnt_next      = 2'd0;
                w_tx_phase_next = 1'b0;
                if (dbus_rsp_ready) begin
                    w_state_next = StTx;
                    if (dbus_rsp_error) begin
                        w_tx_shift_next = {32'h0, RspNak};
                        w_tx_long_next  = 1'b0;
                    end else begin
                        w_tx_shift_next = {dbus_rsp_data, RspAck};
                        w_tx_long_next  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next    = StTx;
                    w_tx_shift_next = {32'h0, RspNak};
                    w_tx_long_next  = 1'b0;
                end
            end
            StTx: begin
                if (w_tx_fire) begin
                    w_tx_shift_next = {8'h00, r_tx_shift[39:8]};
                    if (!r_tx_phase) begin
                        // First byte (ACK/NAK) done; only a good read has data bytes behind it.
                        if (r_tx_long) begin
                            w_tx_phase_next = 1'b1;
                            w_cnt_next      = 2'd0;
                        end else begin
                            w_state_next = StIdle;
                        end
                    end else if (r_cnt == 2'd3) begin
                        w_state_next    = StIdle;
                        w_tx_phase_next = 1'b0;
                        w_cnt_next      = 2'd0;
                    end else begin
                        w_cnt_next = r_cnt + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cnt      <= 2'd0;
            r_is_wr    <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_tx_shift <= 40'h0;
            r_tx_long  <= 1'b0;
            r_tx_phase <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_is_wr    <= w_is_wr_next;
            r_addr     <= w_addr_next;
            r_wdata    <= w_wdata_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_long  <= w_tx_long_next;
            r_tx_phase <= w_tx_phase_next;
        end
    end

endmodule

// File: doc/dbus_byte_master.md
DBUS_BYTE_MASTER -- requirements
Module: dbus_byte_master

Interface
REQ-001 Parameter RSP_TIMEOUT, default 1024: max cycles from command issue to read response before abort (used only with DBUS_MASTER_TIMEOUT_EN).
REQ-002 clk  in  1  sole clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rx_valid  in  1 / rx_data  in  8 / rx_ready  out  1  command byte stream (UART RX side); a byte transfers when valid&&ready.
REQ-005 tx_valid  out  1 / tx_data  out  8 / tx_ready  in  1  response byte stream (UART TX side); a byte transfers when valid&&ready.
REQ-006 dbus_cmd_valid  out  1 / dbus_cmd_ready  in  1  command handshake toward memory/IO responder.
REQ-007 dbus_cmd_payload_wr  out  1 / dbus_cmd_payload_address  out  32 / dbus_cmd_payload_data  out  32 / dbus_cmd_payload_size  out  2  command payload.
REQ-008 dbus_rsp_ready  in  1 / dbus_rsp_error  in  1 / dbus_rsp_data  in  32  read response (valid strobe, error, data); writes produce no response.
REQ-009 busy  out  1  high whenever state != IDLE.

Function
REQ-010 Frame: opcode byte, 4 address bytes little-endian, then for writes 4 data bytes little-endian; opcode 0x57 = write, 0x52 = read.
REQ-011 States: IDLE, ADDR, WDATA, CMD, WAIT_RSP, TX; 2-bit byte counter in ADDR/WDATA/TX.
REQ-012 rx_ready SHALL be high only in IDLE, ADDR, WDATA; low in CMD, WAIT_RSP, TX.
REQ-013 IDLE: 0x57/0x52 -> ADDR; any other opcode -> TX with single byte NAK 0x15.
REQ-014 ADDR after 4th byte: write -> WDATA, read -> CMD; WDATA after 4th byte -> CMD.
REQ-015 dbus_cmd_valid SHALL rise the cycle after the final frame byte transfer and hold with stable payload until dbus_cmd_ready is sampled high.
REQ-016 Payload: size = 2'b10 always (word access); wr = 1 for write, 0 for read; data = 0 for reads.
REQ-017 Write handshake -> TX sending ACK 0x06 only.
REQ-018 Read handshake -> WAIT_RSP next cycle; dbus_rsp_ready is sampled only in WAIT_RSP, and strobes in any other state are ignored.
REQ-019 In WAIT_RSP, rsp_ready with error=0 -> TX sending 0x06 then rsp_data bytes [7:0],[15:8],[23:16],[31:24] (5 bytes); with error=1 -> TX sending NAK 0x15 only.
REQ-020 tx_valid SHALL hold tx_data stable until tx_ready; consecutive bytes with no gap while tx_ready stays high; after last byte -> IDLE.
REQ-021 Response data SHALL be captured into an internal 32-bit register on the rsp strobe; later dbus_rsp_data changes do not affect transmitted bytes.
REQ-022 Back-to-back frames: a new opcode is accepted in IDLE the cycle after the last TX transfer.

Reset
REQ-023 Reset SHALL force IDLE, counters 0, rx_ready 1, tx_valid 0, dbus_cmd_valid 0, payload outputs 0, busy 0.
REQ-024 Reset mid-frame or mid-transaction SHALL abort immediately with no further cmd or tx bytes; partial frames are discarded.

Configuration
REQ-025 Macro DBUS_MASTER_TIMEOUT_EN defined: a cycle counter runs in CMD and WAIT_RSP; on reaching RSP_TIMEOUT-1 the block drops dbus_cmd_valid, goes to TX, and sends NAK 0x15.
REQ-026 DBUS_MASTER_TIMEOUT_EN undefined: no counter logic; CMD/WAIT_RSP wait indefinitely; RSP_TIMEOUT has no effect.

Structure
REQ-027 Shared package dbus_pkg SHALL hold the opcode constants (0x57, 0x52), ACK 0x06, NAK 0x15, the size encoding, and the state enum.
REQ-028 Single module; no sub-module (the byte serializer is an inline shift register plus counter).

Verification
REQ-029 Write frame 57 10 00 00 80 EF BE AD DE, cmd_ready=1 -> one cmd wr=1 addr=0x80000010 data=0xDEADBEEF size=2, then tx 06.
REQ-030 Read frame 52 04 00 00 00, rsp 1 cycle later data=0x12345678 error=0 -> tx 06 78 56 34 12.
REQ-031 Read with rsp error=1 -> tx 15 only; opcode 0x41 -> tx 15, no dbus_cmd_valid.
REQ-032 cmd_ready held low 5 cycles, tx_ready toggled -> payload and tx_data stable until handshake; rx_ready low throughout.
REQ-033 With DBUS_MASTER_TIMEOUT_EN and RSP_TIMEOUT=16, read with no response -> tx 15 after 16 cycles, then back to IDLE.
REQ-034 Reset asserted after 2 address bytes -> no cmd or tx activity; next full frame processed correctly.
